// File: rtl/pu_scheduler.sv
// MAXNET winner-take-all sequencer driving an external 4-input processing unit.
// Define PU_SCHED_EARLY_EXIT_EN to resolve as soon as at most one neuron survives.
module pu_scheduler #(
  parameter logic [31:0] EPS      = 32'hBE000000,
  parameter int          MAX_ITER = 16,
  parameter int          PU_LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic [31:0] x3,
  input  logic [31:0] x4,
  output logic [31:0] pu_a1,
  output logic [31:0] pu_a2,
  output logic [31:0] pu_a3,
  output logic [31:0] pu_a4,
  output logic [31:0] pu_w1,
  output logic [31:0] pu_w2,
  output logic [31:0] pu_w3,
  output logic [31:0] pu_w4,
  input  logic [31:0] pu_out,
  output logic        busy,
  output logic        done,
  output logic [1:0]  winner,
  output logic        winner_valid,
  output logic        timeout,
  output logic [7:0]  iter_count
);

  // state  | meaning
  // IDLE   | waiting for start
  // ISSUE  | four cycles, one neuron's operands per cycle
  // DRAIN  | PU_LAT cycles for the last result to return
  // UPDATE | V <= N, iteration counter +1
  // CHECK  | count survivors and decide
  // DONE   | one-cycle completion pulse

  localparam logic [31:0]    ONE        = 32'h3F800000;
  localparam logic [7:0]     MAX_ITER_B = 8'(MAX_ITER);
  localparam int             DW         = (PU_LAT > 1) ? $clog2(PU_LAT) : 1;
  localparam logic [DW-1:0]  DRAIN_LOAD = DW'(PU_LAT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, UPDATE, CHECK, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic [31:0]       v_q [4];
  logic [31:0]       v_d [4];
  logic [31:0]       n_q [4];
  logic [PU_LAT-1:0] vld_q;
  logic [1:0]        idx_q [PU_LAT];
  logic [1:0]        winner_q, winner_d;
  logic              valid_q, valid_d;
  logic              timeout_q, timeout_d;
  logic [7:0]        iter_q, iter_d;
  logic [3:0]        nz;
  logic [2:0]        nz_cnt;
  logic [1:0]        nz_low;
  logic              resolve;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      drain_q   <= '0;
      winner_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      iter_q    <= '0;
      for (int i = 0; i < 4; i++) v_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      drain_q   <= drain_d;
      winner_q  <= winner_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      iter_q    <= iter_d;
      for (int i = 0; i < 4; i++) v_q[i] <= v_d[i];
    end
  end

  // Tag each issue slot and follow it through the PU latency to steer pu_out into N.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < PU_LAT; i++) idx_q[i] <= '0;
      for (int i = 0; i < 4; i++) n_q[i] <= '0;
    end else begin
      vld_q[0] <= (state_q == ISSUE);
      idx_q[0] <= k_q;
      for (int i = 1; i < PU_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
      if (vld_q[PU_LAT-1]) n_q[idx_q[PU_LAT-1]] <= pu_out;
    end
  end

  always_comb begin
    nz     = '0;
    nz_cnt = '0;
    nz_low = '0;
    for (int i = 3; i >= 0; i--) begin
      nz[i]  = ~v_q[i][31] & (|v_q[i][30:0]);
      nz_cnt = nz_cnt + {2'b00, nz[i]};
      if (nz[i]) nz_low = 2'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    drain_d   = drain_q;
    winner_d  = winner_q;
    valid_d   = valid_q;
    timeout_d = timeout_q;
    iter_d    = iter_q;
    resolve   = 1'b0;
    for (int i = 0; i < 4; i++) v_d[i] = v_q[i];

    case (state_q)
      IDLE: begin
        if (start) begin
          v_d[0]    = x1;
          v_d[1]    = x2;
          v_d[2]    = x3;
          v_d[3]    = x4;
          iter_d    = '0;
          valid_d   = 1'b0;
          timeout_d = 1'b0;
          k_d       = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) begin
          drain_d = DRAIN_LOAD;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_q == '0) state_d = UPDATE;
        else               drain_d = drain_q - 1'b1;
      end
      UPDATE: begin
        for (int i = 0; i < 4; i++) v_d[i] = n_q[i];
        if (iter_q != 8'hFF) iter_d = iter_q + 8'd1;
        state_d = CHECK;
      end
      CHECK: begin
`ifdef PU_SCHED_EARLY_EXIT_EN
        resolve = (nz_cnt < 3'd2) || (iter_q == MAX_ITER_B);
`else
        resolve = (iter_q == MAX_ITER_B);
`endif
        if (resolve) begin
          // nz_low is 0 when nothing survived, giving winner=0 in that case
          winner_d  = nz_low;
          valid_d   = (nz_cnt == 3'd1);
          timeout_d = (nz_cnt > 3'd1);
          state_d   = DONE;
        end else begin
          k_d     = '0;
          state_d = ISSUE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pu_a1 = '0;
    pu_a2 = '0;
    pu_a3 = '0;
    pu_a4 = '0;
    pu_w1 = '0;
    pu_w2 = '0;
    pu_w3 = '0;
    pu_w4 = '0;
    if (state_q == ISSUE) begin
      pu_a1 = v_q[0];
      pu_a2 = v_q[1];
      pu_a3 = v_q[2];
      pu_a4 = v_q[3];
      pu_w1 = (k_q == 2'd0) ? ONE : EPS;
      pu_w2 = (k_q == 2'd1) ? ONE : EPS;
      pu_w3 = (k_q == 2'd2) ? ONE : EPS;
      pu_w4 = (k_q == 2'd3) ? ONE : EPS;
    end
  end

  assign busy         = (state_q != IDLE) && (state_q != DONE);
  assign done         = (state_q == DONE);
  assign winner       = winner_q;
  assign winner_valid = valid_q;
  assign timeout      = timeout_q;
  assign iter_count   = iter_q;

endmodule

// File: tb/tb_pu_scheduler.sv
// Bench for pu_scheduler: behavioural ReLU dot-product PU, reference MAXNET model and scoreboard.
module tb_pu_scheduler;

  localparam int          TB_LAT = 2;
  localparam int          TB_MAX = 16;
  localparam int          PER    = TB_LAT + 6;
  localparam int          BUDGET = 256 * PER + 10;
  localparam logic [31:0] ONE    = 32'h3F800000;
  localparam logic [31:0] EPS    = 32'hBE000000;

  typedef struct packed {
    logic [1:0] winner;
    logic       valid;
    logic       timeout;
    logic [7:0] iter;
  } exp_t;

  logic clk, rst, start0, start1;
  logic [31:0] x1, x2, x3, x4;
  logic [31:0] a1_0, a2_0, a3_0, a4_0, w1_0, w2_0, w3_0, w4_0, out_0;
  logic [31:0] a1_1, a2_1, a3_1, a4_1, w1_1, w2_1, w3_1, w4_1, out_1;
  logic busy0, done0, valid0, tmo0, busy1, done1, valid1, tmo1;
  logic [1:0] win0, win1;
  logic [7:0] iter0, iter1;
  logic [31:0] pipe0 [TB_LAT];
  logic [31:0] pipe1 [TB_LAT];

  int n_chk = 0;
  int n_pass = 0;
  int dcnt0 = 0;
  exp_t sb[$];

  pu_scheduler #(.EPS(EPS), .MAX_ITER(TB_MAX), .PU_LAT(TB_LAT)) dut (
    .clk(clk), .rst(rst), .start(start0), .x1(x1), .x2(x2), .x3(x3), .x4(x4),
    .pu_a1(a1_0), .pu_a2(a2_0), .pu_a3(a3_0), .pu_a4(a4_0),
    .pu_w1(w1_0), .pu_w2(w2_0), .pu_w3(w3_0), .pu_w4(w4_0), .pu_out(out_0),
    .busy(busy0), .done(done0), .winner(win0), .winner_valid(valid0),
    .timeout(tmo0), .iter_count(iter0));

  pu_scheduler #(.EPS(EPS), .MAX_ITER(1), .PU_LAT(TB_LAT)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .x1(x1), .x2(x2), .x3(x3), .x4(x4),
    .pu_a1(a1_1), .pu_a2(a2_1), .pu_a3(a3_1), .pu_a4(a4_1),
    .pu_w1(w1_1), .pu_w2(w2_1), .pu_w3(w3_1), .pu_w4(w4_1), .pu_out(out_1),
    .busy(busy1), .done(done1), .winner(win1), .winner_valid(valid1),
    .timeout(tmo1), .iter_count(iter1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int e;
    if (r <= 0.0) return 32'h0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    if (e <= 0) return 32'h0;
    if (e >= 255) return 32'h7F7FFFFF;
    return {1'b0, 8'(e), d[51:29]};
  endfunction

  function automatic logic [31:0] pu_f(input logic [3:0][31:0] a, input logic [3:0][31:0] w);
    real s;
    s = 0.0;
    for (int j = 0; j < 4; j++) s = s + f2r(a[j]) * f2r(w[j]);
    return r2f(s);
  endfunction

  always @(posedge clk) begin
    pipe0[0] <= pu_f({a4_0, a3_0, a2_0, a1_0}, {w4_0, w3_0, w2_0, w1_0});
    pipe1[0] <= pu_f({a4_1, a3_1, a2_1, a1_1}, {w4_1, w3_1, w2_1, w1_1});
    for (int i = 1; i < TB_LAT; i++) begin
      pipe0[i] <= pipe0[i-1];
      pipe1[i] <= pipe1[i-1];
    end
  end
  assign out_0 = pipe0[TB_LAT-1];
  assign out_1 = pipe1[TB_LAT-1];

  always @(negedge clk) if (done0) dcnt0++;

  // MAXNET reference: neuron k sees weight 1.0 on itself and EPS on the others.
  function automatic exp_t ref_run(input logic [3:0][31:0] x, input int max_it);
    logic [3:0][31:0] v, n, w;
    exp_t r;
    int it, cnt;
    logic [1:0] low;
    v = x;
    it = 0;
    r = '0;
    for (int g = 0; g < 256; g++) begin
      for (int k = 0; k < 4; k++) begin
        for (int j = 0; j < 4; j++) w[j] = (j == k) ? ONE : EPS;
        n[k] = pu_f(v, w);
      end
      v = n;
      if (it < 255) it++;
      cnt = 0;
      low = 2'd0;
      for (int i = 3; i >= 0; i--)
        if (!v[i][31] && v[i][30:0] != 31'd0) begin
          cnt++;
          low = 2'(i);
        end
      r.iter = 8'(it);
`ifdef PU_SCHED_EARLY_EXIT_EN
      if (cnt == 1) begin r.winner = low; r.valid = 1'b1; return r; end
      if (cnt == 0) return r;
      if (it == max_it) begin r.winner = low; r.timeout = 1'b1; return r; end
`else
      if (it == max_it) begin
        if (cnt == 1) begin r.winner = low; r.valid = 1'b1; end
        else if (cnt > 1) begin r.winner = low; r.timeout = 1'b1; end
        return r;
      end
`endif
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic do_run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic [31:0] d, input bit ops, input int dup_at);
    exp_t e;
    int cyc;
    bit got;
    x1 = a; x2 = b; x3 = c; x4 = d;
    sb.push_back(ref_run({d, c, b, a}, TB_MAX));
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    cyc = 1;
    got = 1'b0;
    while (!got && cyc < BUDGET) begin
      if (ops && cyc == 1) begin
        chk("busy_after_start", 32'(busy0), 32'd1);
        chk("k0_a1", a1_0, a);
        chk("k0_a2", a2_0, b);
        chk("k0_a3", a3_0, c);
        chk("k0_a4", a4_0, d);
        chk("k0_w1", w1_0, ONE);
        chk("k0_w2", w2_0, EPS);
        chk("k0_w3", w3_0, EPS);
        chk("k0_w4", w4_0, EPS);
      end
      if (ops && cyc == 2) begin
        chk("k1_w1", w1_0, EPS);
        chk("k1_w2", w2_0, ONE);
      end
      if (cyc == dup_at) begin
        x1 = 32'h3F666666; x2 = 32'h0; x3 = 32'h0; x4 = 32'h0;
        start0 = 1'b1;
      end
      if (cyc == dup_at + 1) start0 = 1'b0;
      if (done0) got = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("done_seen", 32'(got), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("winner", 32'(win0), 32'(e.winner));
      chk("winner_valid", 32'(valid0), 32'(e.valid));
      chk("timeout", 32'(tmo0), 32'(e.timeout));
      chk("iter_count", 32'(iter0), 32'(e.iter));
      chk("latency", 32'(cyc), 32'(int'(e.iter) * PER + 1));
      chk("busy_at_done", 32'(busy0), 32'd0);
      chk("a1_idle", a1_0, 32'h0);
      chk("w4_idle", w4_0, 32'h0);
      @(negedge clk);
      chk("done_one_cycle", 32'(done0), 32'd0);
      repeat (3) @(negedge clk);
      chk("winner_hold", 32'(win0), 32'(e.winner));
      chk("iter_hold", 32'(iter0), 32'(e.iter));
    end
  endtask

  initial begin
    int d0, cyc;
    bit got;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    x1 = '0; x2 = '0; x3 = '0; x4 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_winner", 32'(win0), 32'd0);
    chk("rst_valid", 32'(valid0), 32'd0);
    chk("rst_timeout", 32'(tmo0), 32'd0);
    chk("rst_iter", 32'(iter0), 32'd0);
    chk("rst_a1", a1_0, 32'h0);
    chk("rst_w1", w1_0, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    do_run(32'h3F000000, 32'h3F666666, 32'h3E99999A, 32'h3DCCCCCD, 1'b1, 0);
    chk("classic_winner", 32'(win0), 32'd1);
    chk("classic_valid", 32'(valid0), 32'd1);
    chk("classic_timeout", 32'(tmo0), 32'd0);

    do_run(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 0);
    chk("zero_valid", 32'(valid0), 32'd0);

    d0 = dcnt0;
    do_run(32'h3E4CCCCD, 32'h3DCCCCCD, 32'h3F19999A, 32'h3E99999A, 1'b0, 5);
    repeat (20) @(negedge clk);
    chk("single_done_pulse", 32'(dcnt0 - d0), 32'd1);

    x1 = 32'h3F800000; x2 = 32'h3F000000; x3 = 32'h3E800000; x4 = 32'h0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    d0 = dcnt0;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy0), 32'd0);
    chk("midrst_done", 32'(done0), 32'd0);
    chk("midrst_a1", a1_0, 32'h0);
    chk("midrst_w2", w2_0, 32'h0);
    chk("midrst_winner", 32'(win0), 32'd0);
    chk("midrst_iter", 32'(iter0), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("no_done_after_rst", 32'(dcnt0 - d0), 32'd0);

    do_run(32'h3DCCCCCD, 32'h3E4CCCCD, 32'h3E99999A, 32'h3F666666, 1'b0, 0);

    x1 = 32'h3F800000; x2 = 32'h3F7FFFFF; x3 = 32'h0; x4 = 32'h0;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    cyc = 1;
    got = 1'b0;
    while (!got && cyc < 100) begin
      if (done1) got = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("mi1_done_seen", 32'(got), 32'd1);
    chk("mi1_iter", 32'(iter1), 32'd1);
    chk("mi1_timeout", 32'(tmo1), 32'd1);
    chk("mi1_winner", 32'(win1), 32'd0);
    chk("mi1_valid", 32'(valid1), 32'd0);
    chk("mi1_latency", 32'(cyc), 32'(PER + 1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pu_scheduler.md
PU_SCHEDULER -- requirements
Module: pu_scheduler

Interface
REQ-001 SHALL have parameter EPS, default 32'hBE000000 (-0.125), the off-diagonal inhibition weight.
REQ-002 SHALL have parameter MAX_ITER, default 16, the iteration limit (1..255).
REQ-003 SHALL have parameter PU_LAT, default 2, the cycles from PU operands to valid PU out.
REQ-004 SHALL have port clk  input  1  system clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port start  input  1  single-cycle request to begin a competition.
REQ-007 SHALL have ports x1..x4  input  32 each  initial IEEE-754 single activations, sampled on accepted start.
REQ-008 SHALL have ports pu_a1..pu_a4  output  32 each  activation operands to the PU.
REQ-009 SHALL have ports pu_w1..pu_w4  output  32 each  weight operands to the PU.
REQ-010 SHALL have port pu_out  input  32  PU activation result.
REQ-011 SHALL have port busy  output  1  high from accepted start until done.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port winner  output  2  index 0..3 (x1..x4) of the surviving neuron.
REQ-014 SHALL have port winner_valid  output  1  exactly one neuron survived.
REQ-015 SHALL have port timeout  output  1  MAX_ITER reached without resolution.
REQ-016 SHALL have port iter_count  output  8  iterations completed.

Function
REQ-017 SHALL implement states IDLE, ISSUE, DRAIN, UPDATE, CHECK, DONE.
REQ-018 IDLE: start=1 SHALL latch x1..x4 into vector V, clear iter_count/winner_valid/timeout, enter ISSUE next cycle.
REQ-019 start while busy SHALL be ignored.
REQ-020 ISSUE SHALL last 4 cycles, k=0..3: pu_a1..4 = V; pu_wj = 32'h3F800000 (1.0) for j=k+1, EPS otherwise.
REQ-021 Outside ISSUE, all pu_a and pu_w SHALL be 32'h0.
REQ-022 pu_out SHALL be captured into N[k] exactly PU_LAT cycles after issue cycle k.
REQ-023 DRAIN SHALL last PU_LAT cycles so that N[3] is captured before UPDATE.
REQ-024 UPDATE (1 cycle) SHALL copy N into V and increment iter_count (saturating at 255).
REQ-025 CHECK SHALL count neurons with V[30:0]!=0 and V[31]==0 as nonzero; sign-set or +/-0 count as zero.
REQ-026 CHECK, count==1: SHALL go DONE with winner=that index and winner_valid=1.
REQ-027 CHECK, count==0: SHALL go DONE with winner_valid=0 and winner=0.
REQ-028 CHECK, count>1 and iter_count==MAX_ITER: SHALL go DONE with timeout=1 and winner = lowest-index nonzero neuron.
REQ-029 CHECK otherwise: SHALL return to ISSUE.
REQ-030 DONE SHALL pulse done for one cycle, drop busy, and return to IDLE; winner, winner_valid, timeout, iter_count SHALL hold until the next accepted start.
REQ-031 Iteration period SHALL be 4+PU_LAT+2 cycles.

Reset
REQ-032 rst SHALL asynchronously force IDLE, V=N=0, busy=done=winner_valid=timeout=0, winner=0, iter_count=0, all pu_a/pu_w=0.
REQ-033 rst mid-operation SHALL abandon the competition with no done pulse; next start SHALL begin a clean run.

Configuration
REQ-034 With macro PU_SCHED_EARLY_EXIT_EN defined, CHECK SHALL behave per REQ-026..029.
REQ-035 Without PU_SCHED_EARLY_EXIT_EN, CHECK SHALL ignore count until iter_count==MAX_ITER, then apply REQ-026/027, else set timeout=1 with winner per REQ-028.

Verification
REQ-036 x=3F000000,3F666666,3E99999A,3DCCCCCD, start -> done within 16 iterations, winner=1, winner_valid=1, timeout=0.
REQ-037 x all 32'h0, start -> done after iter_count=1, winner_valid=0, winner=0.
REQ-038 start, then check the cycle after start -> pu_a1..4=x, pu_w1=3F800000, pu_w2..4=BE000000; the next cycle, pu_w2=3F800000.
REQ-039 MAX_ITER=1, x=3F800000,3F7FFFFF,0,0 -> done at iter_count=1, timeout=1, winner=0.
REQ-040 rst asserted during ISSUE -> all outputs 0 immediately, no done pulse; a second start completes normally.
REQ-041 start pulsed while busy -> ignored, V unchanged, single done pulse.
